reg_bus_arbiter: RTL and testbench

REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

---
 rtl/reg_bus_arbiter.sv | 119 +++++++++++
 tb/tb_reg_bus_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter granting NREQ requesters a shared register bus.
// Each transaction runs IDLE -> SETUP -> EXEC; all outputs are registered.
module reg_bus_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int SELW  = 3
) (
  input  logic                    Clk,
  input  logic                    rstN,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         op,
  input  logic [NREQ*SELW-1:0]    sel,
  input  logic [NREQ*WIDTH-1:0]   data,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ-1:0]         grant,
  output logic [WIDTH-1:0]        BusOut,
  output logic [(2**SELW)-1:0]    WEN,
  output logic [(2**SELW)-1:0]    INC,
  output logic                    busy
);

  localparam int NREG = 2 ** SELW;
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     win;
  logic              cop;
  logic [SELW-1:0]   csel;

  logic              hit;
  logic [PW-1:0]     win_n;
  logic [PW:0]       idx;
  logic [NREQ-1:0]   nxt_oh;
  logic [NREQ-1:0]   win_oh;
  logic [NREG-1:0]   sel_oh;

  // Scan from the far end back so the last hit is the first after ptr.
  always_comb begin
    hit   = 1'b0;
    win_n = '0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ))
        idx = idx - (PW+1)'(NREQ);
      if (req[idx[PW-1:0]]) begin
        hit   = 1'b1;
        win_n = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    nxt_oh         = '0;
    nxt_oh[win_n]  = 1'b1;
    win_oh         = '0;
    win_oh[win]    = 1'b1;
    sel_oh         = '0;
    sel_oh[csel]   = 1'b1;
  end

  always_ff @(posedge Clk or negedge rstN) begin
    if (!rstN) begin
      state  <= IDLE;
      ptr    <= '0;
      win    <= '0;
      cop    <= 1'b0;
      csel   <= '0;
      ack    <= '0;
      grant  <= '0;
      BusOut <= '0;
      WEN    <= '0;
      INC    <= '0;
      busy   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            state  <= SETUP;
            win    <= win_n;
            cop    <= op[win_n];
            csel   <= sel[int'(win_n)*SELW +: SELW];
            grant  <= nxt_oh;
            BusOut <= op[win_n] ? '0
                    : data[int'(win_n)*WIDTH +: WIDTH];
            busy   <= 1'b1;
          end
        end
        SETUP: begin
          state <= EXEC;
          ack   <= win_oh;
          if (cop)
            INC <= sel_oh;
          else
            WEN <= sel_oh;
        end
        EXEC: begin
          state  <= IDLE;
          ptr    <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
          ack    <= '0;
          grant  <= '0;
          BusOut <= '0;
          WEN    <= '0;
          INC    <= '0;
          busy   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: latency, ops, round-robin,
// wrap, mid-transaction reset and in-flight input changes.
module tb_reg_bus_arbiter;

  logic        Clk;
  logic        rstN;
  logic [3:0]  req;
  logic [3:0]  op;
  logic [11:0] sel;
  logic [31:0] data;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic [7:0]  BusOut;
  logic [7:0]  WEN;
  logic [7:0]  INC;
  logic        busy;

  int nchk = 0;
  int nerr = 0;
  logic seen7 = 1'b0;

  reg_bus_arbiter #(
    .WIDTH(8),
    .NREQ (4),
    .SELW (3)
  ) dut (
    .Clk   (Clk),
    .rstN  (rstN),
    .req   (req),
    .op    (op),
    .sel   (sel),
    .data  (data),
    .ack   (ack),
    .grant (grant),
    .BusOut(BusOut),
    .WEN   (WEN),
    .INC   (INC),
    .busy  (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk)
    if (WEN[7]) seen7 = 1'b1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    nchk++;
    if (obs !== want) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, ".ack"},   32'(ack),    32'h0);
    chk({tag, ".grant"}, 32'(grant),  32'h0);
    chk({tag, ".bus"},   32'(BusOut), 32'h0);
    chk({tag, ".wen"},   32'(WEN),    32'h0);
    chk({tag, ".inc"},   32'(INC),    32'h0);
    chk({tag, ".busy"},  32'(busy),   32'h0);
  endtask

  task automatic set_req(input int i, input logic o,
                         input logic [2:0] s, input logic [7:0] d);
    op[i]         = o;
    sel[i*3 +: 3] = s;
    data[i*8 +: 8] = d;
  endtask

  logic [3:0] exp_rr [5];
  int last;
  int n;

  initial begin
    exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rstN = 1'b1;
    req  = '0;
    op   = '0;
    sel  = '0;
    data = '0;
    #2 rstN = 1'b0;
    #1 idle_chk("rst");
    repeat (2) @(negedge Clk);
    rstN = 1'b1;
    tick;
    idle_chk("post_rst");

    // single write
    set_req(0, 1'b0, 3'd5, 8'hAA);
    req = 4'b0001;
    tick;
    chk("w.setup.grant", 32'(grant),  32'h1);
    chk("w.setup.bus",   32'(BusOut), 32'hAA);
    chk("w.setup.busy",  32'(busy),   32'h1);
    chk("w.setup.wen",   32'(WEN),    32'h0);
    chk("w.setup.ack",   32'(ack),    32'h0);
    tick;
    chk("w.exec.wen",  32'(WEN),    32'h20);
    chk("w.exec.inc",  32'(INC),    32'h0);
    chk("w.exec.ack",  32'(ack),    32'h1);
    chk("w.exec.bus",  32'(BusOut), 32'hAA);
    req = 4'b0000;
    tick;
    idle_chk("w.done");

    // round-robin from a fresh pointer
    rstN = 1'b0;
    @(negedge Clk);
    rstN = 1'b1;
    for (int i = 0; i < 4; i++)
      set_req(i, 1'b0, 3'(i), 8'(8'h10 + i));
    req  = 4'b1111;
    last = 0;
    n    = 0;
    for (int c = 1; c <= 14; c++) begin
      tick;
      chk("rr.excl", 32'($countones(WEN | INC) <= 1), 32'h1);
      if (ack != 4'b0000) begin
        if (n < 5) chk("rr.ack", 32'(ack), 32'(exp_rr[n]));
        if (n > 0) chk("rr.gap", 32'(c - last), 32'd3);
        last = c;
        n++;
      end
      req = 4'b1111 & ~ack;
    end
    chk("rr.count", 32'(n), 32'd5);
    req = 4'b0000;
    tick;
    tick;
    idle_chk("rr.done");

    // increment by requester 2 (pointer was 1, becomes 3)
    set_req(2, 1'b1, 3'd3, 8'hC3);
    req = 4'b0100;
    tick;
    chk("i.setup.grant", 32'(grant),  32'h4);
    chk("i.setup.bus",   32'(BusOut), 32'h0);
    tick;
    chk("i.exec.inc", 32'(INC),    32'h08);
    chk("i.exec.wen", 32'(WEN),    32'h0);
    chk("i.exec.bus", 32'(BusOut), 32'h0);
    chk("i.exec.ack", 32'(ack),    32'h4);
    req = 4'b0000;
    tick;
    idle_chk("i.done");

    // wrap: requester 3 before requester 0
    set_req(2, 1'b0, 3'd0, 8'h00);
    set_req(3, 1'b0, 3'd6, 8'h77);
    set_req(0, 1'b0, 3'd1, 8'h99);
    req = 4'b1001;
    tick;
    chk("wr.grant3", 32'(grant),  32'h8);
    chk("wr.bus3",   32'(BusOut), 32'h77);
    tick;
    chk("wr.ack3", 32'(ack), 32'h8);
    chk("wr.wen3", 32'(WEN), 32'h40);
    req = 4'b0001;
    tick;
    chk("wr.idle.busy", 32'(busy), 32'h0);
    tick;
    chk("wr.grant0", 32'(grant),  32'h1);
    chk("wr.bus0",   32'(BusOut), 32'h99);
    tick;
    chk("wr.ack0", 32'(ack), 32'h1);
    chk("wr.wen0", 32'(WEN), 32'h02);
    req = 4'b0000;
    tick;
    idle_chk("wr.done");

    // reset during SETUP of a write to register 7
    seen7 = 1'b0;
    set_req(0, 1'b0, 3'd7, 8'h11);
    req = 4'b0001;
    tick;
    chk("mr.setup.grant", 32'(grant), 32'h1);
    rstN = 1'b0;
    req  = 4'b0000;
    #1 idle_chk("mr.async");
    @(negedge Clk);
    idle_chk("mr.held");
    rstN = 1'b1;
    set_req(1, 1'b0, 3'd2, 8'h33);
    req = 4'b0010;
    tick;
    chk("mr.grant1", 32'(grant),  32'h2);
    chk("mr.bus1",   32'(BusOut), 32'h33);
    tick;
    chk("mr.wen1", 32'(WEN), 32'h04);
    chk("mr.ack1", 32'(ack), 32'h2);
    req = 4'b0000;
    tick;
    idle_chk("mr.done");
    chk("mr.no_wen7", 32'(seen7), 32'h0);

    // inputs change and req drops while in flight
    set_req(0, 1'b0, 3'd1, 8'h55);
    req = 4'b0001;
    tick;
    chk("fl.setup.bus", 32'(BusOut), 32'h55);
    set_req(0, 1'b1, 3'd4, 8'hFF);
    req = 4'b0000;
    tick;
    chk("fl.exec.bus", 32'(BusOut), 32'h55);
    chk("fl.exec.wen", 32'(WEN),    32'h02);
    chk("fl.exec.inc", 32'(INC),    32'h0);
    chk("fl.exec.ack", 32'(ack),    32'h1);
    tick;
    idle_chk("fl.done");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
